print_uart_tx: RTL
==================

// Module: print_uart_tx
// PURPOSE
//  Consumer end of the core's PRINT_VAL/PRINT_EN print port (driven by data memory on a print-address store).
//  Buffers each 32-bit print word in a small FIFO.
//  Transmits each word on a UART TX line as 8 lowercase hex ASCII chars (MSB nibble first) followed by LF (0x0A).
//  Sits beside the core at top level; TX goes to the board UART pin.
// PARAMETERS
//  CLKS_PER_BIT  868  CLK cycles per UART bit (100 MHz / 115200)
//  FIFO_DEPTH    4    print words buffered; power of two, >= 2
// PORTS
//  CLK        in   1   system clock, all logic on rising edge
//  RESET      in   1   synchronous, active-low reset (0 = reset)
//  PRINT_VAL  in   32  word to print; valid when PRINT_EN=1
//  PRINT_EN   in   1   one-cycle push strobe; one word per cycle max
//  TX         out  1   UART 8N1 serial out, idle high
//  BUSY       out  1   1 while the FSM is not IDLE or the FIFO is non-empty
//  FIFO_FULL  out  1   FIFO holds FIFO_DEPTH words
//  OVERFLOW   out  1   sticky: a push was dropped; cleared only by reset
// BEHAVIOUR
//  Reset (RESET=0 at an edge): TX=1, BUSY=0, FIFO_FULL=0, OVERFLOW=0, FIFO emptied, FSM=IDLE, counters 0.
//   - Applies mid-frame: the line returns high on that edge; the partial char is abandoned.
//  Push: PRINT_EN=1 at an edge with FIFO not full -> word written.
//   - If full and no pop that cycle -> word dropped, OVERFLOW<=1.
//   - Push and pop in the same cycle when full -> push accepted, count unchanged, no overflow.
//   - Push into empty FIFO with FSM in IDLE -> word written and visible next cycle; it is not bypassed.
//  FSM (all outputs registered): IDLE, START, DATA, STOP.
//   - IDLE: if FIFO non-empty, pop head into hold reg, set char_idx=0, go START. TX low from the edge after the write edge.
//   - START: TX=0 for CLKS_PER_BIT cycles -> DATA, with bit_idx=0.
//   - DATA: TX = char[bit_idx], LSB first, CLKS_PER_BIT cycles per bit. After bit 7 -> STOP.
//   - STOP: TX=1 for CLKS_PER_BIT cycles. Then:
//       - char_idx<8: char_idx++, go START.
//       - char_idx==8 (LF sent): go IDLE; may pop the next word on the next edge.
//  Char encoding: char_idx 0..7 selects nibble hold[31-4*i -: 4].
//   - n<10 -> 8'h30+n; n>=10 -> 8'h57+n ('a'..'f').
//   - char_idx 8 -> 8'h0A.
//  Timing: one frame = 10*CLKS_PER_BIT cycles; one word = 9 frames.
//   - Consecutive frames back-to-back, no extra idle bits.
//   - Back-to-back words: exactly one TX-high cycle (IDLE) between the LF stop bit and the next start bit.
//  Widths and wrap:
//   - Baud counter is $clog2(CLKS_PER_BIT) bits, counts 0..CLKS_PER_BIT-1 and wraps to 0.
//   - char_idx 4 bits (0..8); bit_idx 3 bits.
//   - FIFO pointers $clog2(FIFO_DEPTH) bits, natural wrap; count $clog2(FIFO_DEPTH)+1 bits.
//  PRINT_VAL is ignored when PRINT_EN=0. X on PRINT_VAL with PRINT_EN=0 must not propagate.
// STRUCTURE
//  define.v: FSM state encodings (TX_IDLE, TX_START, TX_DATA, TX_STOP), ASCII_0=8'h30, ASCII_A_M10=8'h57, ASCII_LF=8'h0A.
//  Sub-module print_fifo: synchronous FIFO, params WIDTH=32 and DEPTH.
//   - Ports CLK, RESET, WR_EN, WR_DATA, RD_EN, RD_DATA, FULL, EMPTY.
//   - RD_DATA = head (first-word-fall-through).
//  Top: FSM, baud counter, char encoder and shift logic.
// TESTING (bench uses CLKS_PER_BIT=4, FIFO_DEPTH=4; frame=40 cycles, word=360 cycles)
//  1. Push 32'hDEADBEEF once -> TX decodes "deadbeef\n" (64 65 61 64 62 65 65 66 0A).
//     TX low 1 edge after the write edge; BUSY falls 1 cycle after the LF stop bit.
//  2. Push 32'h0000000A -> "0000000a\n"; first frame bits 0,0,0,0,0,1,1,0,0,1 (start, LSB..MSB, stop).
//  3. Six PRINT_EN strobes on consecutive cycles (values 1..6) -> words 1..5 printed in order.
//     Word 6 dropped; OVERFLOW=1 and stays 1; FIFO_FULL=1 during words 2..5 wait.
//  4. FIFO full, strobe coincides with the IDLE pop edge -> push accepted, OVERFLOW stays 0, 5 words printed.
//  5. RESET=0 for 1 cycle during the DATA bit 3 of char 2 -> TX=1 next cycle, BUSY=0, FIFO empty.
//     A subsequent push of 32'h12345678 prints "12345678\n" cleanly.
//  6. Idle 1000 cycles with PRINT_EN=0 and PRINT_VAL=X -> TX constant 1, BUSY=0, no X on outputs.

Source files
------------

// File: rtl/print_uart_tx_pkg.sv
// Shared definitions for the print UART transmitter: FSM states, ASCII
// constants and the nibble-to-hex character encoder.
package print_uart_tx_pkg;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_A_M10 = 8'h57;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    // Index of the trailing line-feed character within a word
    localparam logic [3:0] LAST_CHAR_IDX = 4'd8;

    // Character idx of a printed word: 0..7 are hex digits MSB first, 8 is LF
    function automatic logic [7:0] encode_char(input logic [31:0] word,
                                               input logic [3:0]  idx);
        logic [4:0]  shamt;
        logic [3:0]  nib;
        logic [7:0]  ch;
        shamt = 5'd28 - {idx[2:0], 2'b00};
        nib   = 4'(word >> shamt);
        if (idx >= LAST_CHAR_IDX) begin
            ch = ASCII_LF;
        end else if (nib < 4'd10) begin
            ch = ASCII_0 + {4'd0, nib};
        end else begin
            ch = ASCII_A_M10 + {4'd0, nib};
        end
        return ch;
    endfunction

endpackage

// File: rtl/print_uart_tx_fifo.sv
// Synchronous first-word-fall-through FIFO holding print words.
// A push when full is accepted only if a pop happens in the same cycle.
module print_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             WR_EN,
    input  logic [WIDTH-1:0] WR_DATA,
    input  logic             RD_EN,
    output logic [WIDTH-1:0] RD_DATA,
    output logic             FULL,
    output logic             EMPTY
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic             do_pop;
    logic             do_push;

    assign FULL    = (count_reg == (PTR_W + 1)'(DEPTH));
    assign EMPTY   = (count_reg == '0);
    assign do_pop  = RD_EN && !EMPTY;
    assign do_push = WR_EN && (!FULL || do_pop);
    assign RD_DATA = mem_reg[rd_ptr_reg];

    // Storage write; contents need no reset since the pointers define validity
    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg] <= WR_DATA;
        end
    end

    // Pointer and occupancy tracking
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/print_uart_tx.sv
// Print-port consumer: buffers 32-bit print words and sends each one over an
// 8N1 UART line as eight lowercase hex digits followed by a line feed.
module print_uart_tx
    import print_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] PRINT_VAL,
    input  logic        PRINT_EN,
    output logic        TX,
    output logic        BUSY,
    output logic        FIFO_FULL,
    output logic        OVERFLOW
);

    localparam int             BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    tx_state_t         state_reg;
    logic [BAUD_W-1:0] baud_cnt_reg;
    logic [3:0]        char_idx_reg;
    logic [2:0]        bit_idx_reg;
    logic [31:0]       hold_reg;
    logic              tx_reg;
    logic              overflow_reg;

    logic [31:0]       fifo_rd_data;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic              baud_last;
    logic [7:0]        cur_char;
    logic [2:0]        bit_idx_next;

    // The FSM only takes a word while idle, so the pop is a pure function of state
    assign fifo_pop     = (state_reg == TX_IDLE) && !fifo_empty;
    assign baud_last    = (baud_cnt_reg == BAUD_LAST);
    assign cur_char     = encode_char(hold_reg, char_idx_reg);
    assign bit_idx_next = bit_idx_reg + 3'd1;

    assign TX        = tx_reg;
    assign BUSY      = (state_reg != TX_IDLE) || !fifo_empty;
    assign FIFO_FULL = fifo_full;
    assign OVERFLOW  = overflow_reg;

    print_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK     (CLK),
        .RESET   (RESET),
        .WR_EN   (PRINT_EN),
        .WR_DATA (PRINT_VAL),
        .RD_EN   (fifo_pop),
        .RD_DATA (fifo_rd_data),
        .FULL    (fifo_full),
        .EMPTY   (fifo_empty)
    );

    // Sticky flag for a push that found the FIFO full with no pop to make room
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            overflow_reg <= 1'b0;
        end else if (PRINT_EN && fifo_full && !fifo_pop) begin
            overflow_reg <= 1'b1;
        end
    end

    // Serializer FSM: start bit, 8 data bits LSB first, stop bit, nine chars per word
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_reg    <= TX_IDLE;
            baud_cnt_reg <= '0;
            char_idx_reg <= '0;
            bit_idx_reg  <= '0;
            hold_reg     <= '0;
            tx_reg       <= 1'b1;
        end else begin
            case (state_reg)
                TX_IDLE: begin
                    baud_cnt_reg <= '0;
                    tx_reg       <= 1'b1;
                    if (!fifo_empty) begin
                        hold_reg     <= fifo_rd_data;
                        char_idx_reg <= '0;
                        bit_idx_reg  <= '0;
                        tx_reg       <= 1'b0;
                        state_reg    <= TX_START;
                    end
                end
                TX_START: begin
                    if (baud_last) begin
                        baud_cnt_reg <= '0;
                        bit_idx_reg  <= '0;
                        tx_reg       <= cur_char[0];
                        state_reg    <= TX_DATA;
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (baud_last) begin
                        baud_cnt_reg <= '0;
                        if (bit_idx_reg == 3'd7) begin
                            tx_reg    <= 1'b1;
                            state_reg <= TX_STOP;
                        end else begin
                            bit_idx_reg <= bit_idx_next;
                            tx_reg      <= cur_char[bit_idx_next];
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 1'b1;
                    end
                end
                TX_STOP: begin
                    if (baud_last) begin
                        baud_cnt_reg <= '0;
                        if (char_idx_reg < LAST_CHAR_IDX) begin
                            char_idx_reg <= char_idx_reg + 4'd1;
                            tx_reg       <= 1'b0;
                            state_reg    <= TX_START;
                        end else begin
                            tx_reg    <= 1'b1;
                            state_reg <= TX_IDLE;
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    tx_reg    <= 1'b1;
                    state_reg <= TX_IDLE;
                end
            endcase
        end
    end

endmodule
